// File: rtl/alsu_param.sv
// alsu_param: two-stage pipelined arithmetic/logic/shift unit, 2*WIDTH-bit result.
// Optional macro ALSU_SHAMT_EN: shift/rotate amount taken from B mod (2*WIDTH).
module alsu_param #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    BLINK_DIV      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    output logic [2*WIDTH-1:0]   out,
    output logic                 valid_out,
    output logic                 invalid,
    output logic [15:0]          leds
);

    localparam int OW      = 2 * WIDTH;
    localparam int SW      = $clog2(OW) + 1;
    localparam int CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam bit PRI_A   = (INPUT_PRIORITY == "A");
    localparam bit ADD_CIN = (FULL_ADDER == "ON");

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SHF = 3'b100;
    localparam logic [2:0] OP_ROT = 3'b101;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_cin;
    logic             s1_sin;
    logic             s1_dir;
    logic             s1_red_a;
    logic             s1_red_b;
    logic             s1_byp_a;
    logic             s1_byp_b;

    logic             byp_any;
    logic             byp_sel_a;
    logic             red_any;
    logic             red_sel_a;
    logic             bad_op;
    logic [WIDTH-1:0] red_src;
    logic [WIDTH:0]   sum;
    logic [OW-1:0]    prod;
    logic [SW-1:0]    shamt;
    logic [OW-1:0]    shl;
    logic [OW-1:0]    shr;
    logic [OW-1:0]    rol;
    logic [OW-1:0]    ror;
    logic [OW-1:0]    res;
    logic             res_bad;
    logic             inv_next;
    logic [CW-1:0]    blink_cnt;

    // Stage 1: capture the input bundle; data holds when no bundle arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_cin   <= 1'b0;
            s1_sin   <= 1'b0;
            s1_dir   <= 1'b0;
            s1_red_a <= 1'b0;
            s1_red_b <= 1'b0;
            s1_byp_a <= 1'b0;
            s1_byp_b <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            if (valid_in) begin
                s1_a     <= A;
                s1_b     <= B;
                s1_op    <= opcode;
                s1_cin   <= cin;
                s1_sin   <= serial_in;
                s1_dir   <= direction;
                s1_red_a <= red_op_A;
                s1_red_b <= red_op_B;
                s1_byp_a <= bypass_A;
                s1_byp_b <= bypass_B;
            end
        end
    end

    // Operand selection and invalid-operation detection
    always_comb begin
        byp_any   = s1_byp_a | s1_byp_b;
        byp_sel_a = s1_byp_a & (~s1_byp_b | PRI_A);
        red_any   = s1_red_a | s1_red_b;
        red_sel_a = s1_red_a & (~s1_red_b | PRI_A);
        red_src   = red_sel_a ? s1_a : s1_b;
        bad_op    = (s1_op[2:1] == 2'b11) |
                    (red_any & (s1_op[2:1] != 2'b00));
    end

    // Arithmetic datapath: adder and full-width multiplier
    always_comb begin
        sum  = {1'b0, s1_a} + {1'b0, s1_b} +
               {{WIDTH{1'b0}}, (ADD_CIN ? s1_cin : 1'b0)};
        prod = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
    end

    // Shift/rotate amount: fixed at 1 unless B-driven amounts are built in
    always_comb begin
`ifdef ALSU_SHAMT_EN
        shamt = SW'(32'(s1_b) % 32'(OW));
`else
        shamt = SW'(1);
`endif
    end

    // Shift and rotate of the current result; vacated bits take serial_in
    always_comb begin
        shl = (out << shamt) |
              (s1_sin ? ~({OW{1'b1}} << shamt) : '0);
        shr = (out >> shamt) |
              (s1_sin ? ~({OW{1'b1}} >> shamt) : '0);
        rol = (out << shamt) | (out >> (SW'(OW) - shamt));
        ror = (out >> shamt) | (out << (SW'(OW) - shamt));
    end

    // Result select: bypass beats invalid, invalid beats opcode
    always_comb begin
        res     = out;
        res_bad = 1'b0;
        if (byp_any) begin
            res = {{WIDTH{1'b0}}, (byp_sel_a ? s1_a : s1_b)};
        end else if (bad_op) begin
            res     = '0;
            res_bad = 1'b1;
        end else begin
            case (s1_op)
                OP_AND: begin
                    if (red_any)
                        res = {{(OW-1){1'b0}}, &red_src};
                    else
                        res = {{WIDTH{1'b0}}, s1_a & s1_b};
                end
                OP_XOR: begin
                    if (red_any)
                        res = {{(OW-1){1'b0}}, ^red_src};
                    else
                        res = {{WIDTH{1'b0}}, s1_a ^ s1_b};
                end
                OP_ADD: res = {{(WIDTH-1){1'b0}}, sum};
                OP_MUL: res = prod;
                OP_SHF: res = s1_dir ? shl : shr;
                OP_ROT: res = s1_dir ? rol : ror;
                default: res = out;
            endcase
        end
    end

    // Flag value after this edge; unchanged while no bundle is in stage 1
    always_comb begin
        inv_next = s1_valid ? res_bad : invalid;
    end

    // Stage 2: publish result, one-cycle valid pulse, sticky invalid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            valid_out <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                out     <= res;
                invalid <= res_bad;
            end
        end
    end

    // LED blinker: all-on when invalid rises, inverts every BLINK_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            leds      <= '0;
            blink_cnt <= '0;
        end else if (!inv_next) begin
            leds      <= '0;
            blink_cnt <= '0;
        end else if (!invalid) begin
            leds      <= 16'hFFFF;
            blink_cnt <= '0;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            leds      <= ~leds;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alsu_param.sv
// tb_alsu_param: directed plus random checks of two alsu_param builds
// against a bit-serial behavioural model of the result and LED rules.
module tb_alsu_param;

    localparam int OW = 6;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] op;
        logic       cin;
        logic       sin;
        logic       dir;
        logic       ra;
        logic       rb;
        logic       ba;
        logic       bb;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [2:0]  A;
    logic [2:0]  B;
    logic [2:0]  opcode;
    logic        cin;
    logic        serial_in;
    logic        direction;
    logic        red_op_A;
    logic        red_op_B;
    logic        bypass_A;
    logic        bypass_B;
    logic [5:0]  o_out [2];
    logic        o_vo [2];
    logic        o_inv [2];
    logic [15:0] o_leds [2];

    int checks = 0;
    int errors = 0;

    int      m_out [2];
    bit      m_inv [2];
    int      m_age [2];
    bit      m_vo;
    bit      p_valid;
    bundle_t p_b;
    int      div [2] = '{4, 2};

    always #5 clk = ~clk;

    alsu_param #(
        .WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .BLINK_DIV(4)
    ) dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(A), .B(B),
        .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .out(o_out[0]),
        .valid_out(o_vo[0]), .invalid(o_inv[0]), .leds(o_leds[0])
    );

    alsu_param #(
        .WIDTH(3), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .BLINK_DIV(2)
    ) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in), .A(A), .B(B),
        .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .out(o_out[1]),
        .valid_out(o_vo[1]), .invalid(o_inv[1]), .leds(o_leds[1])
    );

    // Reference result for one bundle; k=0 is the A-priority/carry-in build
    function automatic int model(input bundle_t x, input int cur,
                                 input int k, output bit bad);
        int r;
        int s;
        int amt;
        bit pa;
        pa  = (k == 0);
        bad = 1'b0;
        r   = cur;
        if (x.ba || x.bb) begin
            r = (x.ba && (!x.bb || pa)) ? int'(x.a) : int'(x.b);
        end else if (x.op >= 6 || ((x.ra || x.rb) && x.op >= 2)) begin
            bad = 1'b1;
            r   = 0;
        end else begin
            s = (x.ra && (!x.rb || pa)) ? int'(x.a) : int'(x.b);
            case (x.op)
                3'd0: r = (x.ra || x.rb) ? int'(s == 7) : int'(x.a & x.b);
                3'd1: r = (x.ra || x.rb) ? ($countones(s) % 2)
                                         : int'(x.a ^ x.b);
                3'd2: r = int'(x.a) + int'(x.b) + (pa ? int'(x.cin) : 0);
                3'd3: r = int'(x.a) * int'(x.b);
                default: begin
`ifdef ALSU_SHAMT_EN
                    amt = int'(x.b) % OW;
`else
                    amt = 1;
`endif
                    repeat (amt) begin
                        if (x.op == 3'd4 && x.dir)
                            r = ((r << 1) | int'(x.sin)) & 63;
                        else if (x.op == 3'd4)
                            r = (r >> 1) | (int'(x.sin) << 5);
                        else if (x.dir)
                            r = ((r << 1) | (r >> 5)) & 63;
                        else
                            r = (r >> 1) | ((r & 1) << 5);
                    end
                end
            endcase
        end
        return r;
    endfunction

    function automatic bundle_t mk(input int op, input int a, input int b);
        bundle_t x;
        x    = '0;
        x.op = 3'(op);
        x.a  = 3'(a);
        x.b  = 3'(b);
        return x;
    endfunction

    task automatic chk(input string tag, input int k,
                       input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d got %h expected %h", tag, k, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs
    task automatic step(input bit r, input bit v, input bundle_t x);
        bit bad;
        bit nb;
        logic [15:0] el;
        rst       = r;
        valid_in  = v;
        A         = x.a;
        B         = x.b;
        opcode    = x.op;
        cin       = x.cin;
        serial_in = x.sin;
        direction = x.dir;
        red_op_A  = x.ra;
        red_op_B  = x.rb;
        bypass_A  = x.ba;
        bypass_B  = x.bb;
        @(posedge clk);
        #1;
        m_vo = r ? 1'b0 : p_valid;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_out[k] = 0;
                m_inv[k] = 1'b0;
                m_age[k] = 0;
            end else begin
                nb = m_inv[k];
                if (p_valid) begin
                    m_out[k] = model(p_b, m_out[k], k, bad);
                    nb = bad;
                end
                m_age[k] = nb ? (m_inv[k] ? m_age[k] + 1 : 0) : 0;
                m_inv[k] = nb;
            end
            el = (m_inv[k] && ((m_age[k] / div[k]) % 2 == 0))
                 ? 16'hFFFF : 16'h0000;
            chk("valid_out", k, 16'(o_vo[k]), 16'(m_vo));
            chk("out", k, 16'(o_out[k]), 16'(m_out[k]));
            chk("invalid", k, 16'(o_inv[k]), 16'(m_inv[k]));
            chk("leds", k, o_leds[k], el);
        end
        p_valid = r ? 1'b0 : v;
        if (v) p_b = x;
    endtask

    initial begin
        bundle_t x;
        bit rr;
        bit vv;
        p_valid = 1'b0;
        p_b     = '0;
        m_vo    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = 0;
            m_inv[k] = 1'b0;
            m_age[k] = 0;
        end
        x = '0;
        step(1, 0, x);
        step(1, 1, x);

        // add 7+7+cin, then idle to see exact latency
        x = mk(2, 7, 7); x.cin = 1'b1;
        step(0, 1, x); step(0, 0, x); step(0, 0, x);

        // multiply and double bypass
        x = mk(3, 7, 7);
        step(0, 1, x); step(0, 0, x); step(0, 0, x);
        x = mk(3, 5, 2); x.ba = 1'b1; x.bb = 1'b1;
        step(0, 1, x); step(0, 0, x); step(0, 0, x);

        // invalid opcode, blink, then a clearing AND
        x = mk(7, 0, 0);
        step(0, 1, x);
        repeat (12) step(0, 0, x);
        x = mk(0, 6, 3);
        step(0, 1, x); step(0, 0, x); step(0, 0, x);

        // seed out=1, three left shifts, one right rotate
        x = mk(0, 1, 0); x.ba = 1'b1;
        step(0, 1, x); step(0, 0, x);
        x = mk(4, 0, 0); x.dir = 1'b1; x.sin = 1'b1;
        step(0, 1, x); step(0, 1, x); step(0, 1, x);
        x = mk(5, 0, 0);
        step(0, 1, x); step(0, 0, x); step(0, 0, x);

        // reduction guard, with and without bypass
        x = mk(2, 3, 5); x.ra = 1'b1;
        step(0, 1, x); step(0, 0, x); step(0, 0, x);
        x.bb = 1'b1;
        step(0, 1, x); step(0, 0, x); step(0, 0, x);

        // both reductions: priority picks the source
        x = mk(1, 3, 7); x.ra = 1'b1; x.rb = 1'b1;
        step(0, 1, x); step(0, 0, x);
        x = mk(0, 7, 3); x.ra = 1'b1; x.rb = 1'b1;
        step(0, 1, x); step(0, 0, x); step(0, 0, x);

        // reset while invalid and with a bundle in flight
        x = mk(6, 0, 0);
        step(0, 1, x); step(0, 0, x);
        x = mk(2, 1, 1);
        step(0, 1, x); step(1, 1, x);
        step(0, 0, x); step(0, 0, x); step(0, 0, x);

        // random traffic
        repeat (400) begin
            x = bundle_t'(16'($urandom));
            if ($urandom_range(3) != 0) begin x.ra = 1'b0; x.rb = 1'b0; end
            if ($urandom_range(3) != 0) begin x.ba = 1'b0; x.bb = 1'b0; end
            vv = ($urandom_range(3) != 0);
            rr = ($urandom_range(60) == 0);
            step(rr, vv, x);
        end
        x = '0;
        step(0, 0, x); step(0, 0, x);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
